match_locator: RTL
==================

MATCH_LOCATOR -- requirements
Module: match_locator

Interface
REQ-001 Parameter POOL_W, default 62: max-pooled correlation map width (columns).
REQ-002 Parameter POOL_H, default 82: max-pooled correlation map height (rows).
REQ-003 Parameter DATA_W, default 21: signed width of a pooled correlation value.
REQ-004 Parameter ADDR_W, default 13: pooled-result RAM address width.
REQ-005 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: one-cycle request to begin a scan.
REQ-008 Port src_done, input, 1: level from the upstream conv/maxpool stage; high means the pooled RAM is complete and readable.
REQ-009 Port threshold, input, DATA_W signed: minimum score for a valid match; sampled when start is accepted.
REQ-010 Port rd_en, output, 1: read enable to the upstream pooled RAM port.
REQ-011 Port rd_addr, output, ADDR_W: read address to the upstream pooled RAM port.
REQ-012 Port rd_data, input, DATA_W signed: RAM read data, valid exactly one cycle after rd_en/rd_addr.
REQ-013 Port busy, output, 1: high in every state except IDLE and DONE.
REQ-014 Port done, output, 1: high while in DONE.
REQ-015 Port best_val, output, DATA_W signed: maximum pooled value found.
REQ-016 Port best_addr, output, ADDR_W: linear address of best_val.
REQ-017 Port best_row, output, 7: row of best_val (best_addr / POOL_W).
REQ-018 Port best_col, output, 6: column of best_val (best_addr mod POOL_W).
REQ-019 Port match_found, output, 1: best_val >= latched threshold (signed compare).

Function
REQ-020 The FSM SHALL have states IDLE, WAIT_SRC, SCAN, DRAIN, DONE.
REQ-021 IDLE or DONE with start=1 SHALL go to WAIT_SRC, latch threshold, and clear done and all result outputs to 0.
REQ-022 WAIT_SRC SHALL stay until src_done=1, then go to SCAN with the address counter at 0.
REQ-023 SCAN SHALL assert rd_en=1 and issue rd_addr 0,1,...,N-1 (N=POOL_W*POOL_H), one address per cycle, with no gaps.
REQ-024 After the cycle that issues address N-1, SCAN SHALL go to DRAIN for exactly one cycle, then to DONE.
REQ-025 rd_en SHALL be 0 outside SCAN, and rd_addr SHALL be 0 outside SCAN.
REQ-026 A one-cycle delayed valid/address/row/col pipeline SHALL tag each rd_data sample with the address that produced it.
REQ-027 Row/col tag counters SHALL advance with the address; col wraps POOL_W-1 -> 0 and increments row.
REQ-028 The first valid sample (address 0) SHALL load best_* unconditionally.
REQ-029 Each later sample SHALL replace best_* only if strictly greater (signed); ties keep the earliest address.
REQ-030 match_found SHALL update in the DRAIN->DONE transition cycle and be valid whenever done=1.
REQ-031 Latency: start accepted at cycle t with src_done already high -> done=1 at cycle t+N+3.
REQ-032 done and all result outputs SHALL hold until the next accepted start or reset.
REQ-033 start in WAIT_SRC, SCAN or DRAIN SHALL be ignored.
REQ-034 If src_done drops during SCAN, the scan SHALL continue; results reflect whatever data was read.
REQ-035 Width rules: N <= 2^ADDR_W, POOL_H <= 128, and POOL_W <= 64 are design-time constraints; the address counter never wraps during a scan.

Reset
REQ-036 reset=1 SHALL, on the next edge, force IDLE and set rd_en, rd_addr, busy, done, best_val, best_addr, best_row, best_col, match_found and the latched threshold to 0.
REQ-037 Reset asserted mid-scan SHALL abort the scan with no further RAM reads; a new start is required.

Verification
REQ-038 Single peak: RAM all -5, address 1000 = 777, threshold=100, start -> done at t+5087; best_addr=1000, row=16, col=8, best_val=777, match_found=1.
REQ-039 Ties: addresses 10 and 4000 = 50, all others 0 -> best_addr=10, row 0, col 10.
REQ-040 All negative: RAM = -(addr+1), threshold=0 -> best_val=-1, best_addr=0, match_found=0.
REQ-041 Gating: start with src_done=0 held for 20 cycles -> rd_en stays 0 and busy=1; raise src_done -> rd_addr 0 issued on the next cycle.
REQ-042 Last-entry and edge case: max value at address 5083 -> row=81, col=61; during the scan, a repeated start is ignored.
REQ-043 Reset mid-scan at address 2000 -> next cycle state IDLE, rd_en=0, all outputs 0; a subsequent start completes normally.

Source files
------------

// File: rtl/match_locator.sv
// Scans the pooled correlation RAM once per start and reports the first location
// holding the maximum value, plus whether it clears the latched threshold.
module match_locator #(
  parameter int unsigned POOL_W = 62,
  parameter int unsigned POOL_H = 82,
  parameter int unsigned DATA_W = 21,
  parameter int unsigned ADDR_W = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     src_done,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     rd_en,
  output logic        [ADDR_W-1:0] rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] best_val,
  output logic        [ADDR_W-1:0] best_addr,
  output logic        [6:0]        best_row,
  output logic        [5:0]        best_col,
  output logic                     match_found
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(POOL_W * POOL_H - 1);
  localparam logic [5:0]        LastCol  = 6'(POOL_W - 1);

  typedef enum logic [2:0] {StIdle, StWaitSrc, StScan, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]        addr_q;
  logic [6:0]               row_q;
  logic [5:0]               col_q;
  logic                     valid_q;
  logic [ADDR_W-1:0]        tag_addr_q;
  logic [6:0]               tag_row_q;
  logic [5:0]               tag_col_q;
  logic signed [DATA_W-1:0] thr_q;
  logic signed [DATA_W-1:0] best_val_q, best_val_d;
  logic [ADDR_W-1:0]        best_addr_q;
  logic [6:0]               best_row_q;
  logic [5:0]               best_col_q;
  logic                     match_q;

  logic scanning, accept, take;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start) state_d = StWaitSrc;
      StWaitSrc:      if (src_done) state_d = StScan;
      StScan:         if (addr_q == LastAddr) state_d = StDrain;
      StDrain:        state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  assign scanning = (state_q == StScan);
  assign accept   = start && (state_q == StIdle || state_q == StDone);
  // Address 0 seeds the search; afterwards only a strictly larger value wins.
  assign take       = valid_q && (tag_addr_q == '0 || rd_data > best_val_q);
  assign best_val_d = take ? rd_data : best_val_q;

  assign rd_en       = scanning;
  assign rd_addr     = scanning ? addr_q : '0;
  assign busy        = (state_q == StWaitSrc) || scanning || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign best_val    = best_val_q;
  assign best_addr   = best_addr_q;
  assign best_row    = best_row_q;
  assign best_col    = best_col_q;
  assign match_found = match_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      valid_q     <= 1'b0;
      tag_addr_q  <= '0;
      tag_row_q   <= '0;
      tag_col_q   <= '0;
      thr_q       <= '0;
      best_val_q  <= '0;
      best_addr_q <= '0;
      best_row_q  <= '0;
      best_col_q  <= '0;
      match_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= scanning;
      tag_addr_q <= addr_q;
      tag_row_q  <= row_q;
      tag_col_q  <= col_q;

      if (state_q == StWaitSrc) begin
        addr_q <= '0;
        row_q  <= '0;
        col_q  <= '0;
      end else if (scanning && addr_q != LastAddr) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (col_q == LastCol) begin
          col_q <= '0;
          row_q <= row_q + 7'd1;
        end else begin
          col_q <= col_q + 6'd1;
        end
      end

      if (accept) begin
        thr_q       <= threshold;
        best_val_q  <= '0;
        best_addr_q <= '0;
        best_row_q  <= '0;
        best_col_q  <= '0;
        match_q     <= 1'b0;
      end else begin
        if (take) begin
          best_val_q  <= rd_data;
          best_addr_q <= tag_addr_q;
          best_row_q  <= tag_row_q;
          best_col_q  <= tag_col_q;
        end
        // The last sample lands during DRAIN, so compare against the post-update best.
        if (state_q == StDrain) match_q <= (best_val_d >= thr_q);
      end
    end
  end

endmodule
